ras_link_stack: RTL and testbench



---
 rtl/ras_link_stack.sv | 198 +++++++++++++++++++
 tb/tb_ras_link_stack.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ras_link_stack.sv
// ras_link_stack
//   Linked-list return-address stack front end. Stack nodes are borrowed
//   from an external free-list allocator on push and handed back on pop.
//   Each node holds a return address (data_mem) and a link to the node
//   below it (link_mem). The top entry is cached in a register so a push
//   is visible on the very next cycle. A pop spends one REFILL cycle
//   reading the new top back out of the synchronous-read memories.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   push, pop          requests, accepted only while ready=1
//   push_data          return address to push
//   ready              IDLE state, can take push/pop this cycle
//   top_valid          stack non-empty
//   top_data           cached top return address (registered)
//   count              live entries, 0..DEPTH
//   full               count == DEPTH
//   overflow/underflow sticky error flags, cleared only by rst_n
//   alloc, alloc_addr  allocator handshake; alloc_addr valid in alloc cycle
//   free, free_addr    return the current head node to the allocator
//
// Optional build macro RAS_LINK_STACK_STATS_EN adds 16-bit saturating
// counters ovf_cnt / unf_cnt of overflowing pushes / underflowing pops.

module ras_link_stack #(
    parameter int ADDR   = 4,
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic              ready,
    output logic              top_valid,
    output logic [DATA_W-1:0] top_data,
    output logic [ADDR:0]     count,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    output logic              alloc,
    input  logic [ADDR-1:0]   alloc_addr,
    output logic              free,
    output logic [ADDR-1:0]   free_addr
`ifdef RAS_LINK_STACK_STATS_EN
    ,
    output logic [15:0]       ovf_cnt,
    output logic [15:0]       unf_cnt
`endif
);

    localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] ONE_C   = (ADDR+1)'(1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t              state_q, state_d;
    logic [ADDR-1:0]     head_q, head_d;
    logic [ADDR-1:0]     head_prev_q, head_prev_d;
    logic [DATA_W-1:0]   top_q, top_d;
    logic [ADDR:0]       count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                ovf_evt, unf_evt;

    // Node storage, no reset (block RAM)
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic [ADDR-1:0]     link_mem [DEPTH];
    logic                dmem_we, lmem_we, rd_en;
    logic [ADDR-1:0]     waddr;
    logic [DATA_W-1:0]   rd_data_q;
    logic [ADDR-1:0]     rd_link_q;

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        head_prev_d = head_prev_q;
        top_d       = top_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        ovf_evt     = 1'b0;
        unf_evt     = 1'b0;
        alloc       = 1'b0;
        free        = 1'b0;
        dmem_we     = 1'b0;
        lmem_we     = 1'b0;
        rd_en       = 1'b0;
        waddr       = alloc_addr;

        case (state_q)
            IDLE: begin
                if (push && pop && count_q != '0) begin
                    // Replace top in place: the head node is reused, so
                    // no allocator traffic and the links stay intact.
                    dmem_we = 1'b1;
                    waddr   = head_q;
                    top_d   = push_data;
                end else if (push) begin
                    // Includes push+pop on an empty stack (plain push).
                    if (count_q == DEPTH_C) begin
                        ovf_d   = 1'b1;
                        ovf_evt = 1'b1;
                    end else begin
                        alloc       = 1'b1;
                        dmem_we     = 1'b1;
                        lmem_we     = 1'b1;
                        head_prev_d = head_q;
                        head_d      = alloc_addr;
                        top_d       = push_data;
                        count_d     = count_q + ONE_C;
                    end
                end else if (pop) begin
                    if (count_q == '0) begin
                        unf_d   = 1'b1;
                        unf_evt = 1'b1;
                    end else if (count_q == ONE_C) begin
                        // Last entry: nothing below to fetch.
                        free    = 1'b1;
                        count_d = '0;
                    end else begin
                        free    = 1'b1;
                        rd_en   = 1'b1;
                        head_d  = head_prev_q;
                        count_d = count_q - ONE_C;
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                top_d       = rd_data_q;
                head_prev_d = rd_link_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            head_q      <= '0;
            head_prev_q <= '0;
            top_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            head_prev_q <= head_prev_d;
            top_q       <= top_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (dmem_we) data_mem[waddr] <= push_data;
        if (lmem_we) link_mem[waddr] <= head_q;
        if (rd_en) begin
            rd_data_q <= data_mem[head_prev_q];
            rd_link_q <= link_mem[head_prev_q];
        end
    end

    assign ready     = (state_q == IDLE);
    assign top_valid = (count_q != '0);
    assign top_data  = top_q;
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign free_addr = head_q;

`ifdef RAS_LINK_STACK_STATS_EN
    logic [15:0] ovf_cnt_q, unf_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else begin
            if (ovf_evt && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
            if (unf_evt && unf_cnt_q != 16'hFFFF) unf_cnt_q <= unf_cnt_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign unf_cnt = unf_cnt_q;
`else
    logic unused_evt;
    assign unused_evt = ovf_evt ^ unf_evt;
`endif

endmodule

// File: tb/tb_ras_link_stack.sv
module tb_ras_link_stack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push, pop;
    logic [31:0] push_data;
    logic        ready, top_valid, full, overflow, underflow;
    logic [31:0] top_data;
    logic [4:0]  count;
    logic        alloc, free;
    logic [3:0]  alloc_addr, free_addr;
`ifdef RAS_LINK_STACK_STATS_EN
    logic [15:0] ovf_cnt, unf_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ras_link_stack #(.ADDR(4), .DEPTH(16), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_data(push_data),
        .ready(ready), .top_valid(top_valid), .top_data(top_data), .count(count),
        .full(full), .overflow(overflow), .underflow(underflow),
        .alloc(alloc), .alloc_addr(alloc_addr), .free(free), .free_addr(free_addr)
`ifdef RAS_LINK_STACK_STATS_EN
        , .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
`endif
    );

    // Free-list allocator model: scrambled initial order so free_addr
    // checks distinguish nodes. Allocated from the front, freed to the back.
    logic [3:0] fl[$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fl.delete();
            for (int i = 0; i < 16; i++) fl.push_back(4'((i*7 + 3) % 16));
            alloc_addr <= 4'd3;
        end else begin
            if (alloc && fl.size() > 0) void'(fl.pop_front());
            if (free) fl.push_back(free_addr);
            alloc_addr <= (fl.size() > 0) ? fl[0] : 4'd0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive at the falling edge and settle; caller samples before the next rise.
    task automatic drive(input logic p, input logic q, input logic [31:0] d);
        @(negedge clk);
        push = p; pop = q; push_data = d;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        push = 0; pop = 0; push_data = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        push, pop;
        logic [31:0] data;
        logic        rdy, al, fr;
        logic [3:0]  fa;
        logic        tv;
        logic [31:0] top;
        logic [4:0]  cnt;
        logic        ovf, unf;
    } vec_t;

    vec_t vecs[19];
    logic [3:0]  nodes[16];

    initial begin
        // expectations are the pre-edge view of the cycle the inputs apply in
        //            push pop data      rdy al fr fa  tv top       cnt ovf unf
        vecs[0]  = '{0, 0, 32'h0,    1, 0, 0, 0,  0, 32'h0,    0, 0, 0};
        vecs[1]  = '{1, 0, 32'h1000, 1, 1, 0, 0,  0, 32'h0,    0, 0, 0};
        vecs[2]  = '{1, 0, 32'h2000, 1, 1, 0, 0,  1, 32'h1000, 1, 0, 0};
        vecs[3]  = '{1, 0, 32'h3000, 1, 1, 0, 0,  1, 32'h2000, 2, 0, 0};
        vecs[4]  = '{0, 0, 32'h0,    1, 0, 0, 0,  1, 32'h3000, 3, 0, 0};
        vecs[5]  = '{0, 1, 32'h0,    1, 0, 1, 1,  1, 32'h3000, 3, 0, 0};
        vecs[6]  = '{0, 0, 32'h0,    0, 0, 0, 0,  1, 32'h3000, 2, 0, 0};
        vecs[7]  = '{0, 0, 32'h0,    1, 0, 0, 0,  1, 32'h2000, 2, 0, 0};
        vecs[8]  = '{1, 1, 32'hAAAA, 1, 0, 0, 0,  1, 32'h2000, 2, 0, 0};
        vecs[9]  = '{0, 0, 32'h0,    1, 0, 0, 0,  1, 32'hAAAA, 2, 0, 0};
        vecs[10] = '{0, 1, 32'h0,    1, 0, 1, 10, 1, 32'hAAAA, 2, 0, 0};
        vecs[11] = '{0, 0, 32'h0,    0, 0, 0, 0,  1, 32'hAAAA, 1, 0, 0};
        vecs[12] = '{0, 0, 32'h0,    1, 0, 0, 0,  1, 32'h1000, 1, 0, 0};
        vecs[13] = '{0, 1, 32'h0,    1, 0, 1, 3,  1, 32'h1000, 1, 0, 0};
        vecs[14] = '{0, 0, 32'h0,    1, 0, 0, 0,  0, 32'h1000, 0, 0, 0};
        vecs[15] = '{0, 1, 32'h0,    1, 0, 0, 0,  0, 32'h1000, 0, 0, 0};
        vecs[16] = '{0, 0, 32'h0,    1, 0, 0, 0,  0, 32'h1000, 0, 0, 1};
        vecs[17] = '{1, 1, 32'h5555, 1, 1, 0, 0,  0, 32'h1000, 0, 0, 1};
        vecs[18] = '{0, 0, 32'h0,    1, 0, 0, 0,  1, 32'h5555, 1, 0, 1};

        push = 0; pop = 0; push_data = '0; rst_n = 1'b0;
        #1;
        chk("async_reset_ready", {31'b0, ready}, 32'd1);
        chk("async_reset_count", {27'b0, count}, 32'd0);
        do_reset();

        // ---- table-driven basic sequence
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].push, vecs[i].pop, vecs[i].data);
            chk($sformatf("v%0d_ready", i), {31'b0, ready}, {31'b0, vecs[i].rdy});
            chk($sformatf("v%0d_alloc", i), {31'b0, alloc}, {31'b0, vecs[i].al});
            chk($sformatf("v%0d_free", i),  {31'b0, free},  {31'b0, vecs[i].fr});
            if (vecs[i].fr) chk($sformatf("v%0d_free_addr", i), {28'b0, free_addr}, {28'b0, vecs[i].fa});
            if (vecs[i].al) chk($sformatf("v%0d_no_free", i), {31'b0, free}, 32'd0);
            chk($sformatf("v%0d_top_valid", i), {31'b0, top_valid}, {31'b0, vecs[i].tv});
            chk($sformatf("v%0d_top_data", i), top_data, vecs[i].top);
            chk($sformatf("v%0d_count", i), {27'b0, count}, {27'b0, vecs[i].cnt});
            chk($sformatf("v%0d_full", i), {31'b0, full}, 32'd0);
            chk($sformatf("v%0d_overflow", i), {31'b0, overflow}, {31'b0, vecs[i].ovf});
            chk($sformatf("v%0d_underflow", i), {31'b0, underflow}, {31'b0, vecs[i].unf});
        end

        // ---- fill to DEPTH, overflow, drain, underflow
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 32'h100 + i);
            nodes[i] = alloc_addr;
            chk("fill_alloc", {31'b0, alloc}, 32'd1);
            chk("fill_ready", {31'b0, ready}, 32'd1);
        end
        drive(0, 0, 0);
        chk("fill_count", {27'b0, count}, 32'd16);
        chk("fill_full", {31'b0, full}, 32'd1);
        chk("fill_top", top_data, 32'h10F);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 32'hDEAD);
            chk("ovf_no_alloc", {31'b0, alloc}, 32'd0);
        end
        drive(0, 0, 0);
        chk("ovf_flag", {31'b0, overflow}, 32'd1);
        chk("ovf_full", {31'b0, full}, 32'd1);
        chk("ovf_top_kept", top_data, 32'h10F);
        chk("ovf_count", {27'b0, count}, 32'd16);
        for (int i = 15; i >= 0; i--) begin
            drive(0, 1, 0);
            chk($sformatf("drain%0d_free", i), {31'b0, free}, 32'd1);
            chk($sformatf("drain%0d_free_addr", i), {28'b0, free_addr}, {28'b0, nodes[i]});
            chk($sformatf("drain%0d_top", i), top_data, 32'h100 + i);
            chk($sformatf("drain%0d_count", i), {27'b0, count}, 32'(i + 1));
            if (i >= 1) begin
                drive(0, 0, 0);
                chk($sformatf("drain%0d_refill_ready", i), {31'b0, ready}, 32'd0);
            end
        end
        drive(0, 0, 0);
        chk("drain_count", {27'b0, count}, 32'd0);
        chk("drain_top_valid", {31'b0, top_valid}, 32'd0);
        chk("drain_ready", {31'b0, ready}, 32'd1);
        chk("drain_unf_clear", {31'b0, underflow}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 0);
            chk("unf_no_free", {31'b0, free}, 32'd0);
        end
        drive(0, 0, 0);
        chk("unf_flag", {31'b0, underflow}, 32'd1);
        chk("ovf_sticky", {31'b0, overflow}, 32'd1);
`ifdef RAS_LINK_STACK_STATS_EN
        chk("ovf_cnt", {16'b0, ovf_cnt}, 32'd3);
        chk("unf_cnt", {16'b0, unf_cnt}, 32'd2);
`endif

        // ---- reset asserted during REFILL
        do_reset();
        drive(1, 0, 32'h77);
        drive(1, 0, 32'h88);
        drive(0, 1, 0);
        drive(0, 0, 0);
        chk("mid_refill_state", {31'b0, ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_top_valid", {31'b0, top_valid}, 32'd0);
        chk("rst_top_data", top_data, 32'd0);
        chk("rst_count", {27'b0, count}, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_alloc", {31'b0, alloc}, 32'd0);
        chk("rst_free", {31'b0, free}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_unf", {31'b0, underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0);
        chk("post_rst_top", top_data, 32'd0);
        chk("post_rst_ready", {31'b0, ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
